// File: rtl/wcc_pkg.sv
// wcc_pkg: state codes, state type and actuator decode shared by the wash cycle controller.
package wcc_pkg;

    localparam int unsigned STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READY = 3'd1;
    localparam logic [2:0] ST_SOAK  = 3'd2;
    localparam logic [2:0] ST_WASH  = 3'd3;
    localparam logic [2:0] ST_RINSE = 3'd4;
    localparam logic [2:0] ST_SPIN  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;
    localparam logic [2:0] ST_FAULT = 3'd7;

    // Event priority inside SOAK..SPIN, highest first:
    //   1. motor failure        -> FAULT
    //   2. cancel               -> SPIN with timer reload (ignored while already in SPIN)
    //   3. lid open             -> pause (WCC_LID_PAUSE_EN) or FAULT
    //   4. out-of-balance, SPIN -> SPIN restart, or FAULT once the restart budget is spent
    //   5. timer expiry         -> next phase

    typedef struct packed {
        logic motor_on;
        logic water_valve;
        logic drain_valve;
        logic done;
        logic fault;
    } act_t;

    // Moore decode of a state code into actuator and status drives.
    function automatic act_t decode_state(state_t s);
        act_t a;
        a.motor_on    = (s == ST_WASH) || (s == ST_RINSE) || (s == ST_SPIN);
        a.water_valve = (s == ST_SOAK) || (s == ST_RINSE);
        a.drain_valve = (s == ST_SPIN);
        a.done        = (s == ST_DONE);
        a.fault       = (s == ST_FAULT);
        return a;
    endfunction

endpackage

// File: rtl/wcc_phase_timer.sv
// wcc_phase_timer: loadable down-counter that stops at zero, with hold and a registered zero flag.
module wcc_phase_timer #(
    parameter int unsigned TIMER_W = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic               hold,
    input  logic [TIMER_W-1:0] load_value,
    output logic               zero
);

    logic [TIMER_W-1:0] count;
    logic [TIMER_W-1:0] count_n;

    // Load wins over hold; otherwise count down and rest at zero.
    always_comb begin
        count_n = count;
        if (load) begin
            count_n = load_value;
        end else if (!hold && (count != '0)) begin
            count_n = count - TIMER_W'(1);
        end
    end

    // Count register with the zero flag tracking the new count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            zero  <= 1'b1;
        end else begin
            count <= count_n;
            zero  <= (count_n == '0);
        end
    end

endmodule

// File: rtl/wash_cycle_controller.sv
// wash_cycle_controller: coin-operated soak/wash/rinse/spin sequencer with internal phase timers.
// Optional feature: define WCC_LID_PAUSE_EN to pause (instead of fault) when the lid opens mid-cycle.
module wash_cycle_controller
    import wcc_pkg::*;
#(
    parameter int unsigned PRICE_COINS   = 2,
    parameter int unsigned SOAK_CYCLES   = 8,
    parameter int unsigned WASH_CYCLES   = 16,
    parameter int unsigned RINSE_CYCLES  = 8,
    parameter int unsigned SPIN_CYCLES   = 12,
    parameter int unsigned RINSE_COUNT   = 2,
    parameter int unsigned MAX_REBALANCE = 3,
    parameter int unsigned TIMER_W       = 16
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                sig_Coin,
    input  logic                                sig_Lid_Closed,
    input  logic                                sig_Cancel,
    input  logic                                sig_Out_Of_Balance,
    input  logic                                sig_Motor_Failure,
    output logic [STATE_W-1:0]                  state,
    output logic [$clog2(PRICE_COINS+1)-1:0]    coin_count,
    output logic                                motor_on,
    output logic                                water_valve,
    output logic                                drain_valve,
    output logic                                done,
    output logic                                fault,
    output logic                                paused,
    output logic                                refund
);

    localparam int unsigned COIN_W  = $clog2(PRICE_COINS + 1);
    localparam int unsigned RIDX_W  = (RINSE_COUNT > 1) ? $clog2(RINSE_COUNT) : 1;
    localparam int unsigned REBAL_W = (MAX_REBALANCE > 0) ? $clog2(MAX_REBALANCE + 1) : 1;

    localparam logic [TIMER_W-1:0] SOAK_LOAD  = TIMER_W'(SOAK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WASH_LOAD  = TIMER_W'(WASH_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RINSE_LOAD = TIMER_W'(RINSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SPIN_LOAD  = TIMER_W'(SPIN_CYCLES - 1);
    localparam logic [COIN_W-1:0]  COIN_FULL  = COIN_W'(PRICE_COINS);
    localparam logic [RIDX_W-1:0]  RIDX_LAST  = RIDX_W'(RINSE_COUNT - 1);
    localparam logic [REBAL_W-1:0] REBAL_MAX  = REBAL_W'(MAX_REBALANCE);

    state_t               state_n;
    logic [COIN_W-1:0]    coin_n;
    logic [RIDX_W-1:0]    ridx;
    logic [RIDX_W-1:0]    ridx_n;
    logic [REBAL_W-1:0]   rebal;
    logic [REBAL_W-1:0]   rebal_n;
    logic                 coin_q;
    logic                 coin_rise;
    logic                 refund_n;
    logic                 paused_n;
    logic                 tmr_load;
    logic                 tmr_hold;
    logic [TIMER_W-1:0]   tmr_val;
    logic                 tmr_zero;
    act_t                 act_n;

    assign coin_rise = sig_Coin & ~coin_q;
    assign act_n     = decode_state(state_n);

    wcc_phase_timer #(
        .TIMER_W    (TIMER_W)
    ) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .hold       (tmr_hold),
        .load_value (tmr_val),
        .zero       (tmr_zero)
    );

    // Next-state, counter and timer-control decode.
    always_comb begin
        state_n  = state;
        coin_n   = coin_count;
        ridx_n   = ridx;
        rebal_n  = rebal;
        refund_n = 1'b0;
        paused_n = 1'b0;
        tmr_load = 1'b0;
        tmr_hold = 1'b0;
        tmr_val  = '0;

        case (state)
            ST_IDLE: begin
                if (sig_Cancel) begin
                    refund_n = (coin_count != '0);
                    coin_n   = '0;
                end else if (coin_count == COIN_FULL) begin
                    state_n = ST_READY;
                end else if (coin_rise) begin
                    coin_n = coin_count + COIN_W'(1);
                end
            end

            ST_READY: begin
                if (sig_Cancel) begin
                    refund_n = (coin_count != '0);
                    coin_n   = '0;
                    state_n  = ST_IDLE;
                end else if (sig_Lid_Closed) begin
                    state_n  = ST_SOAK;
                    tmr_load = 1'b1;
                    tmr_val  = SOAK_LOAD;
                    ridx_n   = '0;
                    rebal_n  = '0;
                end
            end

            ST_SOAK, ST_WASH, ST_RINSE, ST_SPIN: begin
                if (sig_Motor_Failure) begin
                    state_n = ST_FAULT;
                end else if (sig_Cancel && (state != ST_SPIN)) begin
                    state_n  = ST_SPIN;
                    tmr_load = 1'b1;
                    tmr_val  = SPIN_LOAD;
                end else if (!sig_Lid_Closed) begin
`ifdef WCC_LID_PAUSE_EN
                    tmr_hold = 1'b1;
                    paused_n = 1'b1;
`else
                    state_n  = ST_FAULT;
`endif
                end else if ((state == ST_SPIN) && sig_Out_Of_Balance) begin
                    if (rebal == REBAL_MAX) begin
                        state_n = ST_FAULT;
                    end else begin
                        rebal_n  = rebal + REBAL_W'(1);
                        tmr_load = 1'b1;
                        tmr_val  = SPIN_LOAD;
                    end
                end else if (tmr_zero) begin
                    case (state)
                        ST_SOAK: begin
                            state_n  = ST_WASH;
                            tmr_load = 1'b1;
                            tmr_val  = WASH_LOAD;
                        end
                        ST_WASH: begin
                            state_n  = ST_RINSE;
                            tmr_load = 1'b1;
                            tmr_val  = RINSE_LOAD;
                        end
                        ST_RINSE: begin
                            tmr_load = 1'b1;
                            if (ridx < RIDX_LAST) begin
                                ridx_n  = ridx + RIDX_W'(1);
                                tmr_val = RINSE_LOAD;
                            end else begin
                                state_n = ST_SPIN;
                                tmr_val = SPIN_LOAD;
                            end
                        end
                        default: begin
                            state_n = ST_DONE;
                        end
                    endcase
                end
            end

            ST_DONE: begin
                if (!sig_Lid_Closed) begin
                    coin_n  = '0;
                    state_n = ST_IDLE;
                end
            end

            ST_FAULT: begin
                state_n = ST_FAULT;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State register and sequencing counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            coin_count <= '0;
            ridx       <= '0;
            rebal      <= '0;
            coin_q     <= 1'b0;
        end else begin
            state      <= state_n;
            coin_count <= coin_n;
            ridx       <= ridx_n;
            rebal      <= rebal_n;
            coin_q     <= sig_Coin;
        end
    end

    // Registered actuator and status outputs, aligned with the state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            motor_on    <= 1'b0;
            water_valve <= 1'b0;
            drain_valve <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
            paused      <= 1'b0;
            refund      <= 1'b0;
        end else begin
            motor_on    <= act_n.motor_on & ~paused_n;
            water_valve <= act_n.water_valve & ~paused_n;
            drain_valve <= act_n.drain_valve & ~paused_n;
            done        <= act_n.done;
            fault       <= act_n.fault;
            paused      <= paused_n;
            refund      <= refund_n;
        end
    end

endmodule

// File: tb/tb_wash_cycle_controller.sv
// tb_wash_cycle_controller: randomized scenario bench; expected traces are built from phase durations.
module tb_wash_cycle_controller;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READY = 3'd1;
    localparam logic [2:0] S_SOAK  = 3'd2;
    localparam logic [2:0] S_WASH  = 3'd3;
    localparam logic [2:0] S_RINSE = 3'd4;
    localparam logic [2:0] S_SPIN  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_FAULT = 3'd7;

    localparam int PRICE = 2;
    localparam int N_SOAK = 8;
    localparam int N_WASH = 16;
    localparam int N_RINSE = 8;
    localparam int N_SPIN = 12;
    localparam int N_RCOUNT = 2;
    localparam int N_MAXRB = 3;

    logic       clock;
    logic       reset_n;
    logic       sig_Coin;
    logic       sig_Lid_Closed;
    logic       sig_Cancel;
    logic       sig_Out_Of_Balance;
    logic       sig_Motor_Failure;
    logic [2:0] state;
    logic [1:0] coin_count;
    logic       motor_on;
    logic       water_valve;
    logic       drain_valve;
    logic       done;
    logic       fault;
    logic       paused;
    logic       refund;
    logic [6:0] outs;

    int errors = 0;
    int checks = 0;

    logic [2:0] e_st[$];
    bit         e_pz[$];
    bit         i_lid[$];
    bit         i_can[$];
    bit         i_oob[$];
    bit         i_mf[$];
    bit         i_coin[$];

    wash_cycle_controller #(
        .PRICE_COINS   (PRICE),
        .SOAK_CYCLES   (N_SOAK),
        .WASH_CYCLES   (N_WASH),
        .RINSE_CYCLES  (N_RINSE),
        .SPIN_CYCLES   (N_SPIN),
        .RINSE_COUNT   (N_RCOUNT),
        .MAX_REBALANCE (N_MAXRB),
        .TIMER_W       (16)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .sig_Coin           (sig_Coin),
        .sig_Lid_Closed     (sig_Lid_Closed),
        .sig_Cancel         (sig_Cancel),
        .sig_Out_Of_Balance (sig_Out_Of_Balance),
        .sig_Motor_Failure  (sig_Motor_Failure),
        .state              (state),
        .coin_count         (coin_count),
        .motor_on           (motor_on),
        .water_valve        (water_valve),
        .drain_valve        (drain_valve),
        .done               (done),
        .fault              (fault),
        .paused             (paused),
        .refund             (refund)
    );

    assign outs = {motor_on, water_valve, drain_valve, done, fault, paused, refund};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Required output vector for a state, straight from the actuator table.
    function automatic logic [6:0] exp_outs(logic [2:0] st, bit pz);
        logic m, w, d;
        m = (st == S_WASH || st == S_RINSE || st == S_SPIN) && !pz;
        w = (st == S_SOAK || st == S_RINSE) && !pz;
        d = (st == S_SPIN) && !pz;
        return {m, w, d, st == S_DONE, st == S_FAULT, pz, 1'b0};
    endfunction

    function automatic logic [1:0] exp_coins(logic [2:0] st);
        return (st == S_IDLE) ? 2'd0 : 2'(PRICE);
    endfunction

    // 0/1 are fixed levels, 2 means a random level.
    function automatic bit pick(int v);
        return (v == 2) ? 1'($urandom_range(0, 1)) : 1'(v);
    endfunction

    function automatic void clear_sched();
        e_st.delete(); e_pz.delete(); i_lid.delete(); i_can.delete();
        i_oob.delete(); i_mf.delete(); i_coin.delete();
    endfunction

    // Append n cycles whose observed state is st, with the inputs applied before each edge.
    function automatic void push(logic [2:0] st, int n, bit pz, int lid, int can, int oob, int mf, int coin);
        for (int k = 0; k < n; k++) begin
            e_st.push_back(st); e_pz.push_back(pz);
            i_lid.push_back(pick(lid)); i_can.push_back(pick(can));
            i_oob.push_back(pick(oob)); i_mf.push_back(pick(mf)); i_coin.push_back(pick(coin));
        end
    endfunction

    // READY then full SOAK and WASH; out-of-balance and coins are noise here.
    function automatic void push_front();
        push(S_READY, 1, 0, 1, 0, 2, 0, 2);
        push(S_SOAK, N_SOAK, 0, 1, 0, 2, 0, 2);
        push(S_WASH, N_WASH, 0, 1, 0, 2, 0, 2);
    endfunction

    // SPIN segments split by out-of-balance restarts; ends in FAULT or a completed SPIN and DONE.
    function automatic void push_spin(int restarts, bit end_fault, bit first_full);
        int s;
        s = first_full ? N_SPIN : int'($urandom_range(1, N_SPIN));
        push(S_SPIN, s, 0, 1, 2, 0, 0, 2);
        for (int j = 0; j < restarts; j++) begin
            push(S_SPIN, 1, 0, 1, 2, 1, 0, 2);
            s = int'($urandom_range(1, N_SPIN));
            push(S_SPIN, s - 1, 0, 1, 2, 0, 0, 2);
        end
        if (end_fault) begin
            push(S_FAULT, 1, 0, 1, 2, 1, 0, 2);
            push(S_FAULT, 4, 0, 2, 2, 2, 2, 2);
        end else begin
            push(S_SPIN, N_SPIN - s, 0, 1, 2, 0, 0, 2);
            push(S_DONE, 1, 0, 1, 0, 2, 0, 2);
        end
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(int i);
        sig_Lid_Closed     = i_lid[i];
        sig_Cancel         = i_can[i];
        sig_Out_Of_Balance = i_oob[i];
        sig_Motor_Failure  = i_mf[i];
        sig_Coin           = i_coin[i];
        step();
    endtask

    task automatic do_reset();
        sig_Coin = 0; sig_Lid_Closed = 0; sig_Cancel = 0;
        sig_Out_Of_Balance = 0; sig_Motor_Failure = 0;
        reset_n = 0;
        #12;
        @(negedge clock);
        reset_n = 1;
    endtask

    task automatic insert_coins(int n);
        sig_Coin = 0; sig_Cancel = 0;
        step();
        for (int k = 0; k < n; k++) begin
            sig_Coin = 1;
            step();
            sig_Coin = 0;
            if (k < n - 1) step();
        end
    endtask

    task automatic test_reset();
        sig_Coin = 1; sig_Lid_Closed = 1; sig_Cancel = 1;
        sig_Out_Of_Balance = 1; sig_Motor_Failure = 1;
        reset_n = 0;
        #27;
        checks++;
        if ({state, coin_count, outs} !== {S_IDLE, 2'd0, 7'd0}) begin
            errors++;
            $display("FAIL reset: state=%0d coins=%0d outs=%b, expected 0 0 0000000", state, coin_count, outs);
        end
        do_reset();
    endtask

    task automatic test_normal_run();
        do_reset();
        sig_Lid_Closed = 1;
        insert_coins(PRICE);
        checks++;
        if (coin_count !== 2'(PRICE) || state !== S_IDLE) begin
            errors++;
            $display("FAIL normal_coins: coins=%0d state=%0d, expected %0d 0", coin_count, state, PRICE);
        end
        clear_sched();
        push_front();
        push(S_RINSE, N_RCOUNT * N_RINSE, 0, 1, 0, 2, 0, 2);
        push(S_SPIN, N_SPIN, 0, 1, 2, 0, 0, 2);
        push(S_DONE, int'($urandom_range(1, 5)), 0, 1, 0, 2, 0, 2);
        push(S_IDLE, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < e_st.size(); i++) begin
            drive(i);
            checks++;
            if ({state, coin_count, outs} !== {e_st[i], exp_coins(e_st[i]), exp_outs(e_st[i], e_pz[i])}) begin
                errors++;
                $display("FAIL normal_run step %0d: state=%0d coins=%0d outs=%b, expected %0d %0d %b",
                         i, state, coin_count, outs, e_st[i], exp_coins(e_st[i]), exp_outs(e_st[i], e_pz[i]));
            end
        end
    endtask

    task automatic test_coins();
        int hold;
        do_reset();
        hold = int'($urandom_range(2, 6));
        sig_Coin = 1;
        for (int k = 0; k < hold; k++) begin
            step();
            checks++;
            if (coin_count !== 2'd1 || state !== S_IDLE) begin
                errors++;
                $display("FAIL coin_hold cycle %0d: coins=%0d state=%0d, expected 1 0", k, coin_count, state);
            end
        end
        sig_Coin = 0;
        step();
        for (int j = 0; j < 3; j++) begin
            sig_Coin = 1;
            step();
            checks++;
            if (coin_count !== 2'd2 || state !== (j == 0 ? S_IDLE : S_READY)) begin
                errors++;
                $display("FAIL coin_pulse %0d: coins=%0d state=%0d, expected 2 %0d", j, coin_count, state,
                         (j == 0 ? S_IDLE : S_READY));
            end
            sig_Coin = 0;
            for (int g = int'($urandom_range(1, 3)); g > 0; g--) begin
                step();
                checks++;
                if (state !== S_READY || coin_count !== 2'd2) begin
                    errors++;
                    $display("FAIL coin_gap %0d: state=%0d coins=%0d, expected 1 2", j, state, coin_count);
                end
            end
        end
    endtask

    task automatic test_cancel_ready();
        logic [1:0] exp_c;
        logic       exp_r;
        // cancel from READY with 2 coins, then from IDLE with 0 and with 1 coin
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                sig_Coin = 1;
                step();
                sig_Coin = 0;
            end
            exp_r = (k != 1);
            sig_Cancel = 1;
            step();
            sig_Cancel = 0;
            exp_c = 2'd0;
            checks++;
            if (refund !== exp_r || coin_count !== exp_c || state !== S_IDLE) begin
                errors++;
                $display("FAIL cancel_refund %0d: refund=%0b coins=%0d state=%0d, expected %0b 0 0",
                         k, refund, coin_count, state, exp_r);
            end
            step();
            checks++;
            if (refund !== 1'b0) begin
                errors++;
                $display("FAIL cancel_refund_width %0d: refund=%0b, expected 0", k, refund);
            end
        end
    endtask

    task automatic test_cancel_wash();
        int c;
        for (int it = 0; it < 3; it++) begin
            c = (it == 0) ? 5 : (it == 1) ? N_WASH : int'($urandom_range(1, N_WASH));
            do_reset();
            sig_Lid_Closed = 1;
            insert_coins(PRICE);
            clear_sched();
            push(S_READY, 1, 0, 1, 0, 0, 0, 0);
            push(S_SOAK, N_SOAK, 0, 1, 0, 2, 0, 2);
            push(S_WASH, c, 0, 1, 0, 2, 0, 2);
            push(S_SPIN, 1, 0, 1, 1, 2, 0, 2);
            push(S_SPIN, N_SPIN - 1, 0, 1, 2, 0, 0, 2);
            push(S_DONE, 2, 0, 1, 0, 0, 0, 0);
            for (int i = 0; i < e_st.size(); i++) begin
                drive(i);
                checks++;
                if ({state, coin_count, outs} !== {e_st[i], exp_coins(e_st[i]), exp_outs(e_st[i], e_pz[i])}) begin
                    errors++;
                    $display("FAIL cancel_wash c=%0d step %0d: state=%0d coins=%0d outs=%b, expected %0d %0d %b",
                             c, i, state, coin_count, outs, e_st[i], exp_coins(e_st[i]), exp_outs(e_st[i], e_pz[i]));
                end
            end
        end
    endtask

    task automatic test_out_of_balance();
        do_reset();
        sig_Lid_Closed = 1;
        insert_coins(PRICE);
        clear_sched();
        push_front();
        push(S_RINSE, N_RCOUNT * N_RINSE, 0, 1, 0, 2, 0, 2);
        push_spin(N_MAXRB, 1'b1, 1'b1);
        for (int i = 0; i < e_st.size(); i++) begin
            drive(i);
            checks++;
            if ({state, coin_count, outs} !== {e_st[i], exp_coins(e_st[i]), exp_outs(e_st[i], e_pz[i])}) begin
                errors++;
                $display("FAIL out_of_balance step %0d: state=%0d coins=%0d outs=%b, expected %0d %0d %b",
                         i, state, coin_count, outs, e_st[i], exp_coins(e_st[i]), exp_outs(e_st[i], e_pz[i]));
            end
        end
        do_reset();
        step();
        checks++;
        if (state !== S_IDLE || fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_exit_reset: state=%0d fault=%0b, expected 0 0", state, fault);
        end
    endtask

    task automatic test_motor_cancel_rinse();
        int r;
        for (int it = 0; it < 2; it++) begin
            r = int'($urandom_range(1, N_RCOUNT * N_RINSE));
            do_reset();
            sig_Lid_Closed = 1;
            insert_coins(PRICE);
            clear_sched();
            push_front();
            push(S_RINSE, r, 0, 1, 0, 2, 0, 2);
            push(S_FAULT, 1, 0, 1, 1, 2, 1, 2);
            push(S_FAULT, 4, 0, 2, 2, 2, 2, 2);
            for (int i = 0; i < e_st.size(); i++) begin
                drive(i);
                checks++;
                if ({state, coin_count, outs} !== {e_st[i], exp_coins(e_st[i]), exp_outs(e_st[i], e_pz[i])}) begin
                    errors++;
                    $display("FAIL motor_cancel r=%0d step %0d: state=%0d coins=%0d outs=%b, expected %0d %0d %b",
                             r, i, state, coin_count, outs, e_st[i], exp_coins(e_st[i]), exp_outs(e_st[i], e_pz[i]));
                end
            end
        end
    endtask

    task automatic test_lid_open();
        do_reset();
        sig_Lid_Closed = 1;
        insert_coins(PRICE);
        clear_sched();
        push(S_READY, 1, 0, 1, 0, 0, 0, 0);
        push(S_SOAK, 3, 0, 1, 0, 2, 0, 2);
`ifdef WCC_LID_PAUSE_EN
        push(S_SOAK, 4, 1, 0, 0, 2, 0, 2);
        push(S_SOAK, N_SOAK - 3, 0, 1, 0, 2, 0, 2);
        push(S_WASH, N_WASH, 0, 1, 0, 2, 0, 2);
        push(S_RINSE, N_RCOUNT * N_RINSE, 0, 1, 0, 2, 0, 2);
        push(S_SPIN, N_SPIN, 0, 1, 2, 0, 0, 2);
        push(S_DONE, 1, 0, 1, 0, 0, 0, 0);
`else
        push(S_FAULT, 1, 0, 0, 0, 2, 0, 2);
        push(S_FAULT, 4, 0, 2, 2, 2, 2, 2);
`endif
        for (int i = 0; i < e_st.size(); i++) begin
            drive(i);
            checks++;
            if ({state, coin_count, outs} !== {e_st[i], exp_coins(e_st[i]), exp_outs(e_st[i], e_pz[i])}) begin
                errors++;
                $display("FAIL lid_open step %0d: state=%0d coins=%0d outs=%b, expected %0d %0d %b",
                         i, state, coin_count, outs, e_st[i], exp_coins(e_st[i]), exp_outs(e_st[i], e_pz[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int run = 0; run < 2; run++) begin
            insert_coins(PRICE);
            clear_sched();
            push_front();
            push(S_RINSE, N_RCOUNT * N_RINSE, 0, 1, 0, 2, 0, 2);
            push_spin(N_MAXRB, 1'b0, 1'b0);
            push(S_DONE, int'($urandom_range(0, 3)), 0, 1, 0, 2, 0, 2);
            push(S_IDLE, 2, 0, 0, 0, 2, 0, 0);
            for (int i = 0; i < e_st.size(); i++) begin
                drive(i);
                checks++;
                if ({state, coin_count, outs} !== {e_st[i], exp_coins(e_st[i]), exp_outs(e_st[i], e_pz[i])}) begin
                    errors++;
                    $display("FAIL back_to_back run %0d step %0d: state=%0d coins=%0d outs=%b, expected %0d %0d %b",
                             run, i, state, coin_count, outs, e_st[i], exp_coins(e_st[i]), exp_outs(e_st[i], e_pz[i]));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int k;
        k = int'($urandom_range(1, N_WASH));
        do_reset();
        sig_Lid_Closed = 1;
        insert_coins(PRICE);
        clear_sched();
        push(S_READY, 1, 0, 1, 0, 0, 0, 0);
        push(S_SOAK, N_SOAK, 0, 1, 0, 2, 0, 2);
        push(S_WASH, k, 0, 1, 0, 2, 0, 2);
        for (int i = 0; i < e_st.size(); i++) begin
            drive(i);
            checks++;
            if ({state, coin_count, outs} !== {e_st[i], exp_coins(e_st[i]), exp_outs(e_st[i], e_pz[i])}) begin
                errors++;
                $display("FAIL async_reset_pre step %0d: state=%0d coins=%0d outs=%b, expected %0d %0d %b",
                         i, state, coin_count, outs, e_st[i], exp_coins(e_st[i]), exp_outs(e_st[i], e_pz[i]));
            end
        end
        #2;
        reset_n = 0;
        #1;
        checks++;
        if ({state, coin_count, outs} !== {S_IDLE, 2'd0, 7'd0}) begin
            errors++;
            $display("FAIL async_reset: state=%0d coins=%0d outs=%b, expected 0 0 0000000", state, coin_count, outs);
        end
        @(negedge clock);
        reset_n = 1;
        step();
        checks++;
        if ({state, coin_count, refund} !== {S_IDLE, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_after: state=%0d coins=%0d refund=%0b, expected 0 0 0", state, coin_count, refund);
        end
    endtask

    initial begin
        test_reset();
        test_normal_run();
        test_coins();
        test_cancel_ready();
        test_cancel_wash();
        test_out_of_balance();
        test_motor_cancel_rinse();
        test_lid_open();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
